// File: rtl/prog_cnt_timer.sv
// prog_cnt_timer: parametrised loadable up/down counter-timer.
// It has run/pause/stop control, one-shot and auto-reload modes, a direction
// select sampled on start, and a registered terminal-count pulse.
// Optional feature macro: PRESCALE_EN. When it is defined, a PW-bit prescaler
// divides the step rate by presc+1. When it is undefined, the counter steps on
// every RUN cycle and presc is not used.
module prog_cnt_timer #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] init,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode_reload,
    input  logic [PW-1:0]    presc,
    output logic [WIDTH-1:0] count,
    output logic             nz,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

    // Terminal value for a direction: all zeros counting down, all ones up.
    function automatic logic [WIDTH-1:0] term_val(input logic d);
        logic [WIDTH-1:0] t;
        if (d) begin
            t = CNT_ONES;
        end else begin
            t = CNT_ZERO;
        end
        return t;
    endfunction

    // One step in the given direction, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] c,
                                                  input logic d);
        logic [WIDTH-1:0] n;
        if (d) begin
            n = c + CNT_ONE;
        end else begin
            n = c - CNT_ONE;
        end
        return n;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_r;
    logic             dir_r;
    logic             mode_r;
    logic             busy_r;
    logic             tc_r;

    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] next_s;
    logic             at_term_s;
    logic             start_term_s;
    logic             tick_s;

    // Step/terminal decode for the running count and the start-time exception.
    always_comb begin
        term_s       = term_val(dir_r);
        next_s       = step_val(count_r, dir_r);
        // Checking the current count as well covers a reload value that
        // already equals the terminal value.
        at_term_s    = (next_s == term_s) || (count_r == term_s);
        // A one-shot start with the count already at the terminal value for
        // the requested direction only pulses tc and does not run.
        start_term_s = (count_r == term_val(dir)) && !mode_reload;
    end

`ifdef PRESCALE_EN
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);

    logic [PW-1:0] presc_cnt_r;

    assign tick_s = (presc_cnt_r == presc);

    // Prescaler advances only in RUN, clears on a tick, load or fresh start,
    // and holds through PAUSE so a resume continues the partial period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt_r <= PRESC_ZERO;
        end else if (ld) begin
            presc_cnt_r <= PRESC_ZERO;
        end else if (stop) begin
            presc_cnt_r <= presc_cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        presc_cnt_r <= PRESC_ZERO;
                    end else begin
                        presc_cnt_r <= presc_cnt_r;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        presc_cnt_r <= PRESC_ZERO;
                    end else begin
                        presc_cnt_r <= presc_cnt_r + PRESC_ONE;
                    end
                end
                ST_PAUSE: begin
                    presc_cnt_r <= presc_cnt_r;
                end
                default: begin
                    presc_cnt_r <= PRESC_ZERO;
                end
            endcase
        end
    end
`else
    // Without the prescaler every RUN cycle is a tick; presc is left unused.
    logic presc_unused_s;

    assign presc_unused_s = ^presc;
    assign tick_s         = 1'b1;
`endif

    // Main control: load beats stop, stop beats start, start beats a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            dir_r    <= 1'b0;
            mode_r   <= 1'b0;
            busy_r   <= 1'b0;
            tc_r     <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (ld) begin
                count_r  <= init;
                reload_r <= init;
                state_r  <= ST_IDLE;
                busy_r   <= 1'b0;
            end else if (stop) begin
                // Stop only has an effect in RUN; it also masks start.
                case (state_r)
                    ST_RUN: begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b1;
                    end
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    ST_PAUSE: begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            if (start_term_s) begin
                                tc_r <= 1'b1;
                            end else begin
                                dir_r   <= dir;
                                mode_r  <= mode_reload;
                                state_r <= ST_RUN;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        // Resume keeps the direction and mode from the first start.
                        if (start) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_PAUSE;
                        end
                        busy_r <= 1'b1;
                    end
                    ST_RUN: begin
                        if (tick_s) begin
                            if (at_term_s) begin
                                tc_r <= 1'b1;
                                if (mode_r) begin
                                    count_r <= reload_r;
                                    busy_r  <= 1'b1;
                                end else begin
                                    count_r <= term_s;
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end else begin
                                count_r <= next_s;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end
                    default: begin
                        // Unreachable encoding: fall back to a safe idle state.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign tc    = tc_r;
    assign nz    = |count_r;

endmodule
